// File: rtl/wdt_ctrl_regs.sv
// -----------------------------------------------------------------------------
// wdt_ctrl_regs
//
// CPU-visible control/status register block for the watchdog timer. It holds
// the active wait period (loaded through a shadow register on each watchdog
// clear), the reset-pulse length, a software lock and the status flags. It
// also turns KEY writes into a one-cycle o_clrwdt pulse.
//
// Configuration:
//   WDT_KEY_SEQ_EN  defined   -> clearing needs the two-write sequence
//                                0x5555 then 0xAAAA (IDLE/ARMED key FSM).
//                   undefined -> any KEY write clears the watchdog.
//
// Ports:
//   i_clk, i_rst_n       clock (rising edge), async active-low reset
//   i_addr, i_wdata      CPU byte address and store data
//   i_we, i_re           store strobe (one cycle per write), load strobe
//   o_rdata              registered read data, held between loads
//   i_fail_safe,i_hw_rst watchdog status inputs (shown live in STATUS)
//   o_clrwdt             one-cycle watchdog clear pulse
//   o_wait_period        active wait period
//   o_wait_period_w_en   period-load enable, only with o_clrwdt
//   o_rst_period         reset-pulse length
//
// Map (offsets from BASE_ADDR): 0x00 CTRL, 0x04 WAIT, 0x08 RSTP, 0x0C KEY,
// 0x10 STATUS. STATUS = {armed, pend, keyerr, wdtcause, hw_rst, fail_safe}.
// -----------------------------------------------------------------------------
module wdt_ctrl_regs #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter logic [31:0] DEFAULT_WAIT = 32'd1000,
    parameter logic [31:0] DEFAULT_RST  = 32'd16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_we,
    input  logic        i_re,
    output logic [31:0] o_rdata,
    input  logic        i_fail_safe,
    input  logic        i_hw_rst,
    output logic        o_clrwdt,
    output logic [31:0] o_wait_period,
    output logic        o_wait_period_w_en,
    output logic [31:0] o_rst_period
);

    localparam logic [31:0] OFF_CTRL   = 32'h00;
    localparam logic [31:0] OFF_WAIT   = 32'h04;
    localparam logic [31:0] OFF_RSTP   = 32'h08;
    localparam logic [31:0] OFF_KEY    = 32'h0C;
    localparam logic [31:0] OFF_STATUS = 32'h10;

    logic sel_ctrl, sel_wait, sel_rstp, sel_key, sel_status;
    logic wr_ctrl, wr_wait, wr_rstp, wr_key, wr_status;

    assign sel_ctrl   = (i_addr == BASE_ADDR + OFF_CTRL);
    assign sel_wait   = (i_addr == BASE_ADDR + OFF_WAIT);
    assign sel_rstp   = (i_addr == BASE_ADDR + OFF_RSTP);
    assign sel_key    = (i_addr == BASE_ADDR + OFF_KEY);
    assign sel_status = (i_addr == BASE_ADDR + OFF_STATUS);

    assign wr_ctrl   = i_we & sel_ctrl;
    assign wr_wait   = i_we & sel_wait;
    assign wr_rstp   = i_we & sel_rstp;
    assign wr_key    = i_we & sel_key;
    assign wr_status = i_we & sel_status;

    logic        lock, pend, keyerr, wdtcause, hw_rst_q;
    logic [31:0] shadow;
    logic        hw_rise;
    logic        fire;
    logic        key_err_set;
    logic        armed;

    assign hw_rise = i_hw_rst & ~hw_rst_q;

`ifdef WDT_KEY_SEQ_EN
    localparam logic [31:0] KEY_ARM  = 32'h0000_5555;
    localparam logic [31:0] KEY_FIRE = 32'h0000_AAAA;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } key_state_t;

    key_state_t state, state_next;
    logic       wr_other;

    // Any write to a mapped register other than KEY aborts an armed sequence.
    assign wr_other = wr_ctrl | wr_wait | wr_rstp | wr_status;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A hardware-reset edge overrides everything, including a completing
    // key write in the same cycle: the FSM drops to IDLE and no pulse fires.
    always_comb begin
        state_next  = state;
        fire        = 1'b0;
        key_err_set = 1'b0;
        case (state)
            IDLE: begin
                if (wr_key) begin
                    if (i_wdata == KEY_ARM) begin
                        state_next = ARMED;
                    end else begin
                        key_err_set = 1'b1;
                    end
                end
            end
            ARMED: begin
                if (wr_key) begin
                    state_next = IDLE;
                    if (i_wdata == KEY_FIRE) begin
                        fire = 1'b1;
                    end else begin
                        key_err_set = 1'b1;
                    end
                end else if (wr_other) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (hw_rise) begin
            state_next = IDLE;
            fire       = 1'b0;
        end
    end

    assign armed = (state == ARMED);
`else
    assign fire        = wr_key & ~hw_rise;
    assign key_err_set = 1'b0;
    assign armed       = 1'b0;
`endif

    logic [31:0] status_word;
    logic [31:0] rdata_next;

    assign status_word = {26'd0, armed, pend, keyerr, wdtcause, i_hw_rst, i_fail_safe};

    // WAIT reads back the shadow so software sees what it last wrote.
    always_comb begin
        rdata_next = 32'd0;
        if (sel_ctrl) begin
            rdata_next = {31'd0, lock};
        end else if (sel_wait) begin
            rdata_next = shadow;
        end else if (sel_rstp) begin
            rdata_next = o_rst_period;
        end else if (sel_status) begin
            rdata_next = status_word;
        end
    end

    // The new wait period is committed on the same edge that raises
    // o_clrwdt, so it is already valid while the pulse is high. Flag sets
    // are placed after the W1C clears so a simultaneous event wins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_clrwdt           <= 1'b0;
            o_wait_period_w_en <= 1'b0;
            o_rdata            <= 32'd0;
            o_wait_period      <= DEFAULT_WAIT;
            shadow             <= DEFAULT_WAIT;
            o_rst_period       <= DEFAULT_RST;
            lock               <= 1'b0;
            pend               <= 1'b0;
            keyerr             <= 1'b0;
            wdtcause           <= 1'b0;
            hw_rst_q           <= 1'b0;
        end else begin
            hw_rst_q           <= i_hw_rst;
            o_clrwdt           <= fire;
            o_wait_period_w_en <= fire & pend;
            if (wr_ctrl && !lock && i_wdata[0]) begin
                lock <= 1'b1;
            end
            if (wr_wait && !lock) begin
                shadow <= i_wdata;
                pend   <= 1'b1;
            end
            if (wr_rstp && !lock) begin
                o_rst_period <= i_wdata;
            end
            if (fire && pend) begin
                o_wait_period <= shadow;
                pend          <= 1'b0;
            end
            if (wr_status && i_wdata[2]) begin
                wdtcause <= 1'b0;
            end
            if (hw_rise) begin
                wdtcause <= 1'b1;
            end
            if (wr_status && i_wdata[3]) begin
                keyerr <= 1'b0;
            end
            if (key_err_set) begin
                keyerr <= 1'b1;
            end
            if (i_re) begin
                o_rdata <= rdata_next;
            end
        end
    end

endmodule

// File: tb/tb_wdt_ctrl_regs.sv
// -----------------------------------------------------------------------------
// tb_wdt_ctrl_regs
//
// Directed testbench for wdt_ctrl_regs with hand-computed expectations.
// Works in both builds; sequence-specific expectations follow
// WDT_KEY_SEQ_EN.
// -----------------------------------------------------------------------------
module tb_wdt_ctrl_regs;

    localparam logic [31:0] BASE       = 32'hFFFF_0000;
    localparam logic [31:0] OFF_CTRL   = 32'h00;
    localparam logic [31:0] OFF_WAIT   = 32'h04;
    localparam logic [31:0] OFF_RSTP   = 32'h08;
    localparam logic [31:0] OFF_KEY    = 32'h0C;
    localparam logic [31:0] OFF_STATUS = 32'h10;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        i_we;
    logic        i_re;
    logic [31:0] o_rdata;
    logic        i_fail_safe;
    logic        i_hw_rst;
    logic        o_clrwdt;
    logic [31:0] o_wait_period;
    logic        o_wait_period_w_en;
    logic [31:0] o_rst_period;

    int checks = 0;
    int errors = 0;

    wdt_ctrl_regs dut (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .i_addr             (i_addr),
        .i_wdata            (i_wdata),
        .i_we               (i_we),
        .i_re               (i_re),
        .o_rdata            (o_rdata),
        .i_fail_safe        (i_fail_safe),
        .i_hw_rst           (i_hw_rst),
        .o_clrwdt           (o_clrwdt),
        .o_wait_period      (o_wait_period),
        .o_wait_period_w_en (o_wait_period_w_en),
        .o_rst_period       (o_rst_period)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Returns 1 ns after the capturing edge, so registered effects are visible.
    task automatic writeReg(input logic [31:0] off, input logic [31:0] data);
        @(negedge i_clk);
        i_addr  = BASE + off;
        i_wdata = data;
        i_we    = 1'b1;
        @(posedge i_clk);
        #1;
        i_we = 1'b0;
    endtask

    task automatic readReg(input logic [31:0] off, output logic [31:0] data);
        @(negedge i_clk);
        i_addr = BASE + off;
        i_re   = 1'b1;
        @(posedge i_clk);
        #1;
        i_re = 1'b0;
        data = o_rdata;
    endtask

    // Issues the clearing write(s); the caller checks the pulse afterwards.
    task automatic keySequence(input logic [31:0] armed_status);
        logic [31:0] rd;
`ifdef WDT_KEY_SEQ_EN
        writeReg(OFF_KEY, 32'h0000_5555);
        checkOutput("arm_no_pulse", {31'd0, o_clrwdt}, 32'd0);
        readReg(OFF_STATUS, rd);
        checkOutput("status_armed", rd, armed_status);
        writeReg(OFF_KEY, 32'h0000_AAAA);
`else
        rd = armed_status;
        writeReg(OFF_KEY, 32'h0000_AAAA);
`endif
    endtask

    initial begin
        logic [31:0] rd;
        i_rst_n     = 1'b1;
        i_addr      = 32'd0;
        i_wdata     = 32'd0;
        i_we        = 1'b0;
        i_re        = 1'b0;
        i_fail_safe = 1'b0;
        i_hw_rst    = 1'b0;
        #2 i_rst_n = 1'b0;
        #1;
        $display("[TB] reset values");
        checkOutput("rst_clrwdt", {31'd0, o_clrwdt}, 32'd0);
        checkOutput("rst_w_en", {31'd0, o_wait_period_w_en}, 32'd0);
        checkOutput("rst_rdata", o_rdata, 32'd0);
        checkOutput("rst_wait", o_wait_period, 32'd1000);
        checkOutput("rst_rstp", o_rst_period, 32'd16);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        readReg(OFF_STATUS, rd);
        checkOutput("status_after_reset", rd, 32'h00);

        $display("[TB] plain clear");
        keySequence(32'h20);
        checkOutput("clr_pulse", {31'd0, o_clrwdt}, 32'd1);
        checkOutput("clr_w_en", {31'd0, o_wait_period_w_en}, 32'd0);
        checkOutput("clr_wait", o_wait_period, 32'd1000);
        @(posedge i_clk); #1;
        checkOutput("clr_pulse_end", {31'd0, o_clrwdt}, 32'd0);

        $display("[TB] wait period commit");
        writeReg(OFF_WAIT, 32'd500);
        checkOutput("wait_not_yet", o_wait_period, 32'd1000);
        readReg(OFF_STATUS, rd);
        checkOutput("status_pend", rd, 32'h10);
        readReg(OFF_WAIT, rd);
        checkOutput("wait_shadow_read", rd, 32'd500);
        keySequence(32'h30);
        checkOutput("commit_pulse", {31'd0, o_clrwdt}, 32'd1);
        checkOutput("commit_wait", o_wait_period, 32'd500);
        checkOutput("commit_w_en", {31'd0, o_wait_period_w_en}, 32'd1);
        @(posedge i_clk); #1;
        checkOutput("commit_w_en_end", {31'd0, o_wait_period_w_en}, 32'd0);
        checkOutput("commit_pulse_end", {31'd0, o_clrwdt}, 32'd0);
        readReg(OFF_STATUS, rd);
        checkOutput("status_pend_clear", rd, 32'h00);

        $display("[TB] wrong key and aborted sequence");
`ifdef WDT_KEY_SEQ_EN
        writeReg(OFF_KEY, 32'h0000_5555);
        writeReg(OFF_KEY, 32'h0000_1234);
        checkOutput("badkey_no_pulse", {31'd0, o_clrwdt}, 32'd0);
        readReg(OFF_STATUS, rd);
        checkOutput("status_keyerr", rd, 32'h08);
        writeReg(OFF_STATUS, 32'h08);
        readReg(OFF_STATUS, rd);
        checkOutput("status_keyerr_clr", rd, 32'h00);
        writeReg(OFF_KEY, 32'h0000_AAAA);
        checkOutput("idle_fire_no_pulse", {31'd0, o_clrwdt}, 32'd0);
        readReg(OFF_STATUS, rd);
        checkOutput("status_idle_keyerr", rd, 32'h08);
        writeReg(OFF_STATUS, 32'h08);
        writeReg(OFF_KEY, 32'h0000_5555);
        writeReg(OFF_RSTP, 32'd20);
        checkOutput("rstp_update", o_rst_period, 32'd20);
        readReg(OFF_STATUS, rd);
        checkOutput("status_aborted", rd, 32'h00);
        writeReg(OFF_KEY, 32'h0000_AAAA);
        checkOutput("aborted_no_pulse", {31'd0, o_clrwdt}, 32'd0);
        writeReg(OFF_STATUS, 32'h08);
`else
        writeReg(OFF_KEY, 32'h0000_1234);
        checkOutput("anykey_pulse", {31'd0, o_clrwdt}, 32'd1);
        readReg(OFF_STATUS, rd);
        checkOutput("status_no_keyerr", rd, 32'h00);
        writeReg(OFF_RSTP, 32'd20);
        checkOutput("rstp_update", o_rst_period, 32'd20);
`endif

        $display("[TB] live status bits");
        i_fail_safe = 1'b1;
        readReg(OFF_STATUS, rd);
        checkOutput("status_fail_safe", rd, 32'h01);
        i_fail_safe = 1'b0;

        $display("[TB] hw reset edge against completing key write");
`ifdef WDT_KEY_SEQ_EN
        writeReg(OFF_KEY, 32'h0000_5555);
`endif
        @(negedge i_clk);
        i_addr   = BASE + OFF_KEY;
        i_wdata  = 32'h0000_AAAA;
        i_we     = 1'b1;
        i_hw_rst = 1'b1;
        @(posedge i_clk); #1;
        i_we = 1'b0;
        checkOutput("hwrst_no_pulse", {31'd0, o_clrwdt}, 32'd0);
        @(posedge i_clk); #1;
        checkOutput("hwrst_no_pulse_late", {31'd0, o_clrwdt}, 32'd0);
        readReg(OFF_STATUS, rd);
        checkOutput("status_hwrst", rd, 32'h06);
        i_hw_rst = 1'b0;
        writeReg(OFF_STATUS, 32'h00);
        readReg(OFF_STATUS, rd);
        checkOutput("status_w0_keeps", rd, 32'h04);
        writeReg(OFF_STATUS, 32'h04);
        readReg(OFF_STATUS, rd);
        checkOutput("status_cause_clr", rd, 32'h00);

        $display("[TB] read path");
        readReg(32'h14, rd);
        checkOutput("unmapped_read", rd, 32'h00);
        readReg(OFF_RSTP, rd);
        checkOutput("rstp_read", rd, 32'd20);
        @(negedge i_clk);
        i_addr = BASE + 32'h14;
        @(posedge i_clk); #1;
        checkOutput("rdata_hold", o_rdata, 32'd20);

        $display("[TB] reset mid-sequence");
`ifdef WDT_KEY_SEQ_EN
        writeReg(OFF_KEY, 32'h0000_5555);
`endif
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        checkOutput("midrst_wait", o_wait_period, 32'd1000);
        checkOutput("midrst_rstp", o_rst_period, 32'd16);
        checkOutput("midrst_rdata", o_rdata, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge i_clk); #1;
            checkOutput("midrst_no_pulse", {31'd0, o_clrwdt}, 32'd0);
        end
        readReg(OFF_STATUS, rd);
        checkOutput("midrst_status", rd, 32'h00);

        $display("[TB] lock");
        writeReg(OFF_CTRL, 32'd1);
        readReg(OFF_CTRL, rd);
        checkOutput("lock_set", rd, 32'd1);
        writeReg(OFF_CTRL, 32'd0);
        readReg(OFF_CTRL, rd);
        checkOutput("lock_sticky", rd, 32'd1);
        writeReg(OFF_WAIT, 32'd7);
        writeReg(OFF_RSTP, 32'd3);
        checkOutput("lock_wait", o_wait_period, 32'd1000);
        checkOutput("lock_rstp", o_rst_period, 32'd16);
        readReg(OFF_STATUS, rd);
        checkOutput("lock_no_pend", rd, 32'h00);
        keySequence(32'h20);
        checkOutput("lock_clr_pulse", {31'd0, o_clrwdt}, 32'd1);
        checkOutput("lock_clr_w_en", {31'd0, o_wait_period_w_en}, 32'd0);
        checkOutput("lock_clr_wait", o_wait_period, 32'd1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wdt_ctrl_regs.md
WDT_CTRL_REGS -- requirements
Module: wdt_ctrl_regs

Interface
REQ-001 Parameter: BASE_ADDR, default 32'hFFFF_0000, byte address of the register block.
REQ-002 Parameter: DEFAULT_WAIT, default 32'd1000, reset value of the active wait period.
REQ-003 Parameter: DEFAULT_RST, default 32'd16, reset value of the reset-pulse period.
REQ-004 Port: i_clk, input, 1, single clock; all logic on the rising edge.
REQ-005 Port: i_rst_n, input, 1, reset; asynchronous, active-low.
REQ-006 Port: i_addr, input, 32, CPU byte address.
REQ-007 Port: i_wdata, input, 32, CPU store data.
REQ-008 Port: i_we, input, 1, store strobe, one cycle per write.
REQ-009 Port: i_re, input, 1, load strobe.
REQ-010 Port: o_rdata, output, 32, read data, registered.
REQ-011 Port: i_fail_safe, input, 1, watchdog fail-safe status.
REQ-012 Port: i_hw_rst, input, 1, watchdog hardware-reset status.
REQ-013 Port: o_clrwdt, output, 1, one-cycle watchdog clear pulse.
REQ-014 Port: o_wait_period, output, 32, active wait period.
REQ-015 Port: o_wait_period_w_en, output, 1, period-load enable, valid only with o_clrwdt.
REQ-016 Port: o_rst_period, output, 32, reset-pulse length.

Function
REQ-017 Register map SHALL be BASE_ADDR offsets: 0x00 CTRL, 0x04 WAIT, 0x08 RSTP, 0x0C KEY, 0x10 STATUS; other addresses read 0, writes ignored.
REQ-018 CTRL SHALL hold bit0 LOCK, set-only by software; once set, writes to CTRL, WAIT and RSTP are ignored until reset.
REQ-019 A WAIT write SHALL load a 32-bit shadow and set PEND; o_wait_period SHALL NOT change until commit.
REQ-020 An RSTP write SHALL update o_rst_period on the next clock edge.
REQ-021 Key FSM states SHALL be IDLE and ARMED; KEY write 32'h0000_5555 in IDLE -> ARMED.
REQ-022 In ARMED, KEY write 32'h0000_AAAA SHALL pulse o_clrwdt high for exactly one cycle, starting the cycle after the write, and return to IDLE.
REQ-023 In ARMED, any other KEY value or any write to another mapped register SHALL return to IDLE, with no pulse; a wrong KEY value SHALL set STATUS.KEYERR.
REQ-024 In IDLE, a KEY write other than 32'h0000_5555 SHALL set STATUS.KEYERR and stay in IDLE.
REQ-025 When o_clrwdt pulses with PEND=1: o_wait_period SHALL take the shadow value in the same cycle, o_wait_period_w_en SHALL be 1 for that cycle, and PEND SHALL clear.
REQ-026 STATUS SHALL read: bit0 i_fail_safe (live), bit1 i_hw_rst (live), bit2 WDTCAUSE, bit3 KEYERR, bit4 PEND, bit5 FSM state is ARMED.
REQ-027 Writing 1 to STATUS bit2 or bit3 SHALL clear that bit; writing 0 SHALL leave it unchanged.
REQ-028 A rising edge of i_hw_rst SHALL set WDTCAUSE and force the FSM to IDLE.
REQ-029 If that rising edge and a completing key write occur in the same cycle, the edge SHALL win and no o_clrwdt pulse SHALL occur.
REQ-030 Read data SHALL appear on o_rdata one cycle after i_re; o_rdata SHALL hold its value otherwise.
REQ-031 Reads SHALL NOT change FSM state or flags.

Reset
REQ-032 On i_rst_n=0, the block SHALL immediately apply these values: o_clrwdt=0, o_wait_period_w_en=0, o_rdata=0, o_wait_period=DEFAULT_WAIT, shadow=DEFAULT_WAIT, o_rst_period=DEFAULT_RST, LOCK=0, PEND=0, KEYERR=0, WDTCAUSE=0, FSM=IDLE.
REQ-033 Reset asserted mid-sequence (ARMED) SHALL discard the sequence; no pulse SHALL occur after release.

Configuration
REQ-034 Macro WDT_KEY_SEQ_EN defined: the two-write key FSM of REQ-021..REQ-024 SHALL apply.
REQ-035 Macro WDT_KEY_SEQ_EN undefined: any KEY write SHALL pulse o_clrwdt the next cycle, KEYERR SHALL stay 0, and STATUS bit5 SHALL read 0.

Verification
REQ-036 Write KEY 0x5555 then 0xAAAA -> o_clrwdt=1 for exactly one cycle; o_wait_period_w_en=0; o_wait_period=1000.
REQ-037 Write WAIT=500, then the key sequence -> STATUS.PEND=1 before; at the pulse o_wait_period=500 and o_wait_period_w_en=1; PEND=0 after.
REQ-038 Write KEY 0x5555, then 0x1234 -> no pulse; STATUS reads 0x08; write STATUS 0x08 -> reads 0x00.
REQ-039 Write CTRL=1, then WAIT=7 and RSTP=3 -> o_wait_period=1000 and o_rst_period=16 remain; PEND=0.
REQ-040 Raise i_hw_rst in the same cycle as the 0xAAAA write -> no o_clrwdt; STATUS bits 1 and 2 set; FSM=IDLE.
